// File: rtl/squeeze1x1_agu.sv
// Loop-nest controller and address generator for the SqueezeNet 1x1 squeeze layer.
// Walks filter groups, lines, cells and channel groups and emits one image/weight/output beat per handshake.
module squeeze1x1_agu #(
  parameter int PC = 16,
  parameter int PF = 8,
  parameter int AW = 24,
  parameter int CW = 10,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_inch,
  input  logic [SW-1:0] cfg_size,
  input  logic [CW-1:0] cfg_filt,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [AW-1:0] o_img_addr,
  output logic [AW-1:0] o_wgt_addr,
  output logic [AW-1:0] o_out_addr,
  output logic [CW-1:0] o_filt,
  output logic          o_first,
  output logic          o_last
);

  localparam int PF_SH = $clog2(PF);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          launch_q, launch_d;
  logic [CW-1:0] inch_q, inch_d, filt_q, filt_d;
  logic [SW-1:0] size_q, size_d;
  logic [AW-1:0] s2_q, s2_d;
  logic [CW-1:0] ch_q, ch_d, f_q, f_d;
  logic [SW-1:0] cell_q, cell_d, line_q, line_d;
  logic [AW-1:0] ch_img_q, ch_img_d, line_base_q, line_base_d;
  logic [AW-1:0] f_wgt_q, f_wgt_d, f_out_q, f_out_d;
  logic          busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic          o_valid_q, o_valid_d, o_first_q, o_first_d, o_last_q, o_last_d;
  logic [AW-1:0] o_img_q, o_img_d, o_wgt_q, o_wgt_d, o_out_q, o_out_d;
  logic [CW-1:0] o_filt_q, o_filt_d;

  logic          rst_meta_q, rst_sync_q;
  logic [2*SW-1:0] s2_full;
  logic          cfg_bad, fire, last_ch, last_cell, last_line, last_f;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign s2_full   = {{SW{1'b0}}, size_q} * {{SW{1'b0}}, size_q};
  assign cfg_bad   = (cfg_inch == '0) || ((cfg_inch & CW'(PC - 1)) != '0) ||
                     (cfg_size == '0) ||
                     (cfg_filt == '0) || ((cfg_filt & CW'(PF - 1)) != '0);
  assign fire      = o_valid_q & o_ready;
  assign last_ch   = (ch_q == inch_q - CW'(PC));
  assign last_cell = (cell_q == size_q - SW'(1));
  assign last_line = (line_q == size_q - SW'(1));
  assign last_f    = (f_q == filt_q - CW'(PF));

  always_comb begin
    state_d     = state_q;
    launch_d    = 1'b0;
    inch_d      = inch_q;
    size_d      = size_q;
    filt_d      = filt_q;
    s2_d        = s2_q;
    ch_d        = ch_q;
    cell_d      = cell_q;
    line_d      = line_q;
    f_d         = f_q;
    ch_img_d    = ch_img_q;
    line_base_d = line_base_q;
    f_wgt_d     = f_wgt_q;
    f_out_d     = f_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    o_valid_d   = o_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            inch_d      = cfg_inch;
            size_d      = cfg_size;
            filt_d      = cfg_filt;
            ch_d        = '0;
            cell_d      = '0;
            line_d      = '0;
            f_d         = '0;
            ch_img_d    = '0;
            line_base_d = '0;
            f_wgt_d     = '0;
            f_out_d     = '0;
            launch_d    = 1'b1;
            busy_d      = 1'b1;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (launch_q) begin
          s2_d      = AW'(s2_full);
          o_valid_d = 1'b1;
        end else if (fire) begin
          if (last_ch && last_cell && last_line && last_f) begin
            o_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end else if (!last_ch) begin
            // Image memory is banked PC channels wide: one S*S plane per channel group.
            ch_d     = ch_q + CW'(PC);
            ch_img_d = ch_img_q + s2_q;
          end else begin
            ch_d     = '0;
            ch_img_d = '0;
            if (!last_cell) begin
              cell_d = cell_q + SW'(1);
            end else begin
              cell_d = '0;
              if (!last_line) begin
                line_d      = line_q + SW'(1);
                line_base_d = line_base_q + AW'(size_q);
              end else begin
                line_d      = '0;
                line_base_d = '0;
                f_d         = f_q + CW'(PF);
                f_wgt_d     = f_wgt_q + (AW'(inch_q) << PF_SH);
                f_out_d     = f_out_q + (s2_q << PF_SH);
              end
            end
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next counter state so a stalled beat holds steady.
    o_img_d   = ch_img_d + line_base_d + AW'(cell_d);
    o_wgt_d   = f_wgt_d + AW'(ch_d);
    o_out_d   = f_out_d + line_base_d + AW'(cell_d);
    o_filt_d  = f_d;
    o_first_d = o_valid_d && (ch_d == '0);
    o_last_d  = o_valid_d && (ch_d == inch_d - CW'(PC));
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= IDLE;
      launch_q    <= 1'b0;
      inch_q      <= '0;
      size_q      <= '0;
      filt_q      <= '0;
      s2_q        <= '0;
      ch_q        <= '0;
      cell_q      <= '0;
      line_q      <= '0;
      f_q         <= '0;
      ch_img_q    <= '0;
      line_base_q <= '0;
      f_wgt_q     <= '0;
      f_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_img_q     <= '0;
      o_wgt_q     <= '0;
      o_out_q     <= '0;
      o_filt_q    <= '0;
      o_first_q   <= 1'b0;
      o_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      inch_q      <= inch_d;
      size_q      <= size_d;
      filt_q      <= filt_d;
      s2_q        <= s2_d;
      ch_q        <= ch_d;
      cell_q      <= cell_d;
      line_q      <= line_d;
      f_q         <= f_d;
      ch_img_q    <= ch_img_d;
      line_base_q <= line_base_d;
      f_wgt_q     <= f_wgt_d;
      f_out_q     <= f_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      o_valid_q   <= o_valid_d;
      o_img_q     <= o_img_d;
      o_wgt_q     <= o_wgt_d;
      o_out_q     <= o_out_d;
      o_filt_q    <= o_filt_d;
      o_first_q   <= o_first_d;
      o_last_q    <= o_last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign o_valid    = o_valid_q;
  assign o_img_addr = o_img_q;
  assign o_wgt_addr = o_wgt_q;
  assign o_out_addr = o_out_q;
  assign o_filt     = o_filt_q;
  assign o_first    = o_first_q;
  assign o_last     = o_last_q;

endmodule

// File: tb/tb_squeeze1x1_agu.sv
// Scoreboard bench for squeeze1x1_agu: stimulus pushes expected beats, a monitor pops them on each fire.
module tb_squeeze1x1_agu;
  localparam int PC = 16, PF = 8, AW = 24, CW = 10, SW = 8;

  typedef struct packed {
    logic [AW-1:0] img;
    logic [AW-1:0] wgt;
    logic [AW-1:0] out;
    logic [CW-1:0] filt;
    logic          first;
    logic          last;
  } beat_t;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, o_ready = 1'b1;
  logic [CW-1:0] cfg_inch = '0, cfg_filt = '0;
  logic [SW-1:0] cfg_size = '0;
  logic          busy, done, cfg_err, o_valid, o_first, o_last;
  logic [AW-1:0] o_img_addr, o_wgt_addr, o_out_addr;
  logic [CW-1:0] o_filt;

  beat_t exp_q[$];
  beat_t mon_e, held;
  logic  stall_prev = 1'b0;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, beat_cnt = 0, last_fire_cyc = -10, done_pulses = 0, err_pulses = 0;
  int run_base = 0, hand_mode = 0;

  squeeze1x1_agu #(.PC(PC), .PF(PF), .AW(AW), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_inch(cfg_inch), .cfg_size(cfg_size), .cfg_filt(cfg_filt),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_img_addr(o_img_addr), .o_wgt_addr(o_wgt_addr), .o_out_addr(o_out_addr),
    .o_filt(o_filt), .o_first(o_first), .o_last(o_last)
  );

  always #5 clk = ~clk;

  function automatic beat_t cur();
    cur = {o_img_addr, o_wgt_addr, o_out_addr, o_filt, o_first, o_last};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: compares each fired beat against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_chk++;
        if (cur() !== held) begin
          n_fail++;
          $display("FAIL stall_stable: got %h expected %h", cur(), held);
        end
      end
      if (o_valid && o_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got beat img=%0d expected none", o_img_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (cur() !== mon_e) begin
            n_fail++;
            $display("FAIL beat_%0d: got img=%0d wgt=%0d out=%0d f=%0d first=%b last=%b expected img=%0d wgt=%0d out=%0d f=%0d first=%b last=%b",
                     beat_cnt - run_base, o_img_addr, o_wgt_addr, o_out_addr, o_filt, o_first, o_last,
                     mon_e.img, mon_e.wgt, mon_e.out, mon_e.filt, mon_e.first, mon_e.last);
          end
        end
        if (hand_mode == 1) begin
          case (beat_cnt - run_base)
            0: begin
              chk("b0_img", o_img_addr, 0); chk("b0_wgt", o_wgt_addr, 0);
              chk("b0_out", o_out_addr, 0); chk("b0_first", o_first, 1);
            end
            1: begin chk("b1_img", o_img_addr, 3025); chk("b1_wgt", o_wgt_addr, 16); end
            3: begin
              chk("b3_img", o_img_addr, 9075); chk("b3_wgt", o_wgt_addr, 48); chk("b3_last", o_last, 1);
            end
            4: begin
              chk("b4_img", o_img_addr, 1); chk("b4_out", o_out_addr, 1); chk("b4_first", o_first, 1);
            end
            12100: begin
              chk("b12100_f", o_filt, 8); chk("b12100_wgt", o_wgt_addr, 512); chk("b12100_out", o_out_addr, 24200);
            end
            default: ;
          endcase
        end else if (hand_mode == 2 && beat_cnt == run_base) begin
          chk("min_first", o_first, 1); chk("min_last", o_last, 1);
          chk("min_img", o_img_addr, 0); chk("min_wgt", o_wgt_addr, 0); chk("min_out", o_out_addr, 0);
        end
        beat_cnt++;
        last_fire_cyc = cyc;
      end
      stall_prev = o_valid && !o_ready;
      held = cur();
      if (done) done_pulses++;
      if (cfg_err) err_pulses++;
    end
  end

  task automatic push_model(input int inch, input int s, input int filt);
    beat_t b;
    for (int f = 0; f < filt; f += PF)
      for (int ln = 0; ln < s; ln++)
        for (int cl = 0; cl < s; cl++)
          for (int ch = 0; ch < inch; ch += PC) begin
            b.img   = AW'((ch / PC) * s * s + ln * s + cl);
            b.wgt   = AW'(f * inch + ch);
            b.out   = AW'(f * s * s + ln * s + cl);
            b.filt  = CW'(f);
            b.first = (ch == 0);
            b.last  = (ch == inch - PC);
            exp_q.push_back(b);
          end
  endtask

  task automatic launch(input int inch, input int s, input int filt, input bit good);
    @(posedge clk); #1;
    cfg_inch = CW'(inch); cfg_size = SW'(s); cfg_filt = CW'(filt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    if (good) begin
      chk("launch_valid_lo", o_valid, 0);
    end else begin
      chk("bad_cfg_err", cfg_err, 1); chk("bad_busy", busy, 0); chk("bad_valid", o_valid, 0);
      @(negedge clk); #1;
      chk("bad_err_pulse", cfg_err, 0); chk("bad_busy2", busy, 0); chk("bad_valid2", o_valid, 0);
      $display("bad config inch=%0d size=%0d filt=%0d rejected", inch, s, filt);
    end
  endtask

  task automatic run_cfg(input int inch, input int s, input int filt,
                         input bit rand_ready, input bit spam, input int hmode);
    int total, errs0, dones0, n;
    bit got;
    total = (filt / PF) * s * s * (inch / PC);
    push_model(inch, s, filt);
    run_base = beat_cnt; errs0 = err_pulses; dones0 = done_pulses; hand_mode = hmode;
    o_ready = 1'b1;
    launch(inch, s, filt, 1'b1);
    got = 1'b0; n = 0;
    while (!got && n < 60000) begin
      @(posedge clk); #1;
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (spam && (beat_cnt - run_base) < total - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk); #1;
      n++;
      if (n == 1) begin chk("beat0_valid", o_valid, 1); chk("beat0_busy", busy, 1); end
      if (done) got = 1'b1;
    end
    start = 1'b0; o_ready = 1'b1; hand_mode = 0;
    chk("done_seen", got, 1);
    chk("beat_count", beat_cnt - run_base, total);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_latency", cyc - last_fire_cyc, 1);
    chk("done_valid_lo", o_valid, 0);
    chk("done_busy_hi", busy, 1);
    chk("no_cfg_err", err_pulses - errs0, 0);
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_drop", busy, 0);
    chk("done_count", done_pulses - dones0, 1);
    exp_q.delete();
    $display("run inch=%0d size=%0d filt=%0d beats=%0d", inch, s, filt, beat_cnt - run_base);
  endtask

  initial begin
    int n, dones0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", cfg_err, 0);
    chk("rst_valid", o_valid, 0); chk("rst_first", o_first, 0); chk("rst_last", o_last, 0);
    chk("rst_img", o_img_addr, 0); chk("rst_wgt", o_wgt_addr, 0);
    chk("rst_out", o_out_addr, 0); chk("rst_filt", o_filt, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    run_cfg(64, 55, 16, 1'b0, 1'b0, 1);
    run_cfg(16, 1, 8, 1'b0, 1'b0, 2);
    launch(72, 5, 8, 1'b0);
    launch(64, 5, 12, 1'b0);
    launch(64, 0, 8, 1'b0);
    run_cfg(64, 5, 16, 1'b1, 1'b1, 0);
    run_cfg(32, 3, 16, 1'b1, 1'b0, 0);

    // Reset in the middle of a run, between clock edges.
    push_model(64, 55, 16);
    run_base = beat_cnt; dones0 = done_pulses; o_ready = 1'b1;
    launch(64, 55, 16, 1'b1);
    n = 0;
    while ((beat_cnt - run_base) < 500 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_beat500", beat_cnt - run_base, 500);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_img", o_img_addr, 0); chk("mid_rst_wgt", o_wgt_addr, 0); chk("mid_rst_out", o_out_addr, 0);
    chk("mid_rst_first", o_first, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rst_no_done", done_pulses - dones0, 0);
    $display("reset mid-run after %0d beats", beat_cnt - run_base);
    run_cfg(32, 3, 8, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
